// File: rtl/hilo_div_sequencer.sv
// hilo_div_sequencer: multi-cycle radix-2 restoring divider and HI/LO write sequencer (optional DIV_ZERO_FAST_EN)
module hilo_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    output logic             stall,
    output logic             busy,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = $clog2(WIDTH) + 1;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, nxt;
    logic [CW-1:0]    cnt;
    logic             sa, sb, zero, accept, last, nb;
    logic [WIDTH-1:0] rem, quo, dvs, hold_hi, hold_lo;
    logic [WIDTH-1:0] ma, mb, diff, fix_hi, fix_lo;
    logic [WIDTH:0]   r_sh;

    assign ma     = (signed_op && opa[WIDTH-1]) ? -opa : opa;
    assign mb     = (signed_op && opb[WIDTH-1]) ? -opb : opb;
    assign r_sh   = {rem, quo[WIDTH-1]};
    assign nb     = r_sh >= {1'b0, dvs};
    assign diff   = r_sh[WIDTH-1:0] - dvs;
    assign fix_lo = zero ? '1 : (sa ^ sb) ? -quo : quo;
    assign fix_hi = sa ? -rem : rem;
    assign hi_out = (state == DONE && !cancel) ? fix_hi : hold_hi;
    assign lo_out = (state == DONE && !cancel) ? fix_lo : hold_lo;
    assign busy   = state != IDLE;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // next state and pipeline handshake; cancel suppresses stall and write in the same cycle
    always_comb begin
        nxt     = state;
        stall   = 1'b0;
        hilo_we = 1'b0;
        accept  = 1'b0;
        last    = cnt == CW'(WIDTH - 1);
        case (state)
            IDLE: begin
                accept = start && !cancel;
                stall  = accept;
                nxt    = !accept ? IDLE : (FAST && opb == '0) ? DONE : BUSY;
            end
            BUSY: begin
                stall = !cancel;
                nxt   = cancel ? IDLE : last ? DONE : BUSY;
            end
            default: begin
                hilo_we = !cancel;
                nxt     = IDLE;
            end
        endcase
    end

    // operand capture, one shift/subtract step per BUSY cycle, and result hold on write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            zero    <= 1'b0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            hold_hi <= '0;
            hold_lo <= '0;
        end else if (accept) begin
            cnt  <= '0;
            sa   <= signed_op && opa[WIDTH-1];
            sb   <= signed_op && opb[WIDTH-1];
            zero <= opb == '0;
            dvs  <= mb;
            rem  <= (FAST && opb == '0) ? ma : '0;
            quo  <= (FAST && opb == '0) ? '1 : ma;
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            rem <= nb ? diff : r_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], nb};
        end else if (state == DONE && !cancel) begin
            hold_hi <= fix_hi;
            hold_lo <= fix_lo;
        end
    end
endmodule

// File: tb/tb_hilo_div_sequencer.sv
// tb_hilo_div_sequencer: scoreboard bench for the HI/LO divide sequencer
module tb_hilo_div_sequencer;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, signed_op = 1'b0, cancel = 1'b0;
    logic [31:0] opa = '0, opb = '0;
    logic        stall, busy, hilo_we;
    logic [31:0] hi_out, lo_out;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZL = 1;
`else
    localparam int ZL = 33;
`endif

    hilo_div_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .opa(opa), .opb(opb), .cancel(cancel), .stall(stall), .busy(busy),
        .hilo_we(hilo_we), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    int          cyc = 0, acc_cyc = 0, total = 0, bad = 0, ml;
    logic [63:0] expq[$], me;
    int          latq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // monitor: every write strobe is matched against the oldest expected result
    always @(negedge clk) begin
        if (hilo_we) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual=1 required=0");
            end else begin
                me = expq.pop_front();
                ml = latq.pop_front();
                chk("hi", hi_out, me[63:32]);
                chk("lo", lo_out, me[31:0]);
                chk("latency", 32'(cyc - acc_cyc), 32'(ml));
            end
        end
    end

    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int lat);
        int nst = 0;
        bit seen = 0;
        @(posedge clk); #1;
        signed_op = s; opa = a; opb = b; start = 1'b1; acc_cyc = cyc;
        expq.push_back({ehi, elo});
        latq.push_back(lat);
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (stall) nst++;
            if (hilo_we) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL timeout actual=no_write required=write");
            expq.delete();
            latq.delete();
        end
        chk("stall_cycles", 32'(nst), 32'(lat));
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_we", {31'd0, hilo_we}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        @(negedge clk); rst = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33);
        run_op(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14, 33);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33);
        run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33);
        run_op(1'b0, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 33);
        run_op(1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, ZL);
        run_op(1'b0, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, ZL);

        @(posedge clk); #1;
        signed_op = 1'b0; opa = 32'd100; opb = 32'd7; start = 1'b1;
        repeat (10) @(posedge clk);
        #1 cancel = 1'b1;
        @(negedge clk);
        chk("cancel_stall", {31'd0, stall}, 32'd0);
        chk("cancel_we", {31'd0, hilo_we}, 32'd0);
        chk("cancel_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        cancel = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("cancel_idle", {31'd0, busy}, 32'd0);
        chk("cancel_hi_hold", hi_out, 32'h12345678);
        chk("cancel_lo_hold", lo_out, 32'hFFFFFFFF);
        run_op(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);

        @(posedge clk); #1;
        signed_op = 1'b0; opa = 32'd100; opb = 32'd7; start = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        #1;
        chk("mrst_stall", {31'd0, stall}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_we", {31'd0, hilo_we}, 32'd0);
        chk("mrst_hi", hi_out, 32'd0);
        chk("mrst_lo", lo_out, 32'd0);
        @(negedge clk); rst = 1'b1;
        run_op(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 33);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hilo_div_sequencer.md
Name: hilo_div_sequencer

Overview:
- Multi-cycle radix-2 divide unit and sequencer for the HI/LO register pair, sitting beside the execute stage of the 5-stage MIPS pipeline.
- Accepts a DIV/DIVU from execute, stalls the pipeline while it iterates, then issues a one-cycle HI/LO write.
- Owns the iteration datapath (shift/subtract) and the sequencing FSM. Honours pipeline flush.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- start  input  1  execute stage holds a valid DIV/DIVU
- signed_op  input  1  1 = DIV (signed), 0 = DIVU; sampled at accept
- opa  input  WIDTH  dividend (rs), sampled at accept
- opb  input  WIDTH  divisor (rt), sampled at accept
- cancel  input  1  flush/exception kill of execute stage
- stall  output  1  freeze F/D/E stages
- busy  output  1  FSM not IDLE
- hilo_we  output  1  one-cycle HI/LO write strobe
- hi_out  output  WIDTH  remainder
- lo_out  output  WIDTH  quotient

Behaviour:
- States: IDLE, BUSY, DONE. Iteration counter is $clog2(WIDTH)+1 bits.
- Reset (rst=0, async): state IDLE, counter 0, internal registers 0; stall=0, busy=0, hilo_we=0, hi_out=0, lo_out=0.
- Accept: in IDLE with start=1 and cancel=0. This is cycle 0.
  - Latch signed_op and operand signs.
  - Latch magnitudes |opa| and |opb| (unsigned if signed_op=0). 0x80000000 yields magnitude 0x80000000.
  - Go to BUSY.
  - stall is combinational: high in cycle 0 from start & IDLE & !cancel.
- BUSY:
  - One restoring iteration per cycle, cycles 1..WIDTH.
  - Partial remainder is WIDTH+1 bits. Shift left, trial subtract divisor; quotient bit = no borrow.
  - stall=1 and busy=1 throughout.
  - After iteration WIDTH, go to DONE.
- DONE (cycle WIDTH+1):
  - hilo_we=1 for exactly one cycle; stall=0 so the pipeline advances; busy=1.
  - hi_out/lo_out are valid this cycle and hold until the next accept.
  - Next state IDLE.
  - start is still high in DONE (same instruction) and is ignored; no restart.
- Sign fix-up, applied in DONE from latched signs:
  - Quotient is negated if the operand signs differ (signed only).
  - Remainder takes the sign of the dividend.
  - Two's-complement wrap: 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0.
- Divide by zero (opb=0, either mode): lo=all ones, hi=opa (original value, no sign fix). No trap.
- Total latency from accept to hilo_we: WIDTH+1 cycles; stall high for WIDTH+1 cycles.
- start while BUSY/DONE: ignored (pipeline is stalled, so it is the same instruction).
- Cancel:
  - In IDLE: no accept; stall=0.
  - In BUSY or DONE: stall and hilo_we are forced 0 combinationally that cycle; next state IDLE; hi_out/lo_out keep their previous values.
- Reset mid-operation: immediate IDLE, all outputs 0; no write is issued.

Optional Feature:
- Macro DIV_ZERO_FAST_EN.
- Defined: divisor zero is detected at accept; FSM goes straight to DONE. hilo_we fires in cycle 1 and stall is high only in cycle 0. Results are the same as above.
- Undefined: divisor zero runs all WIDTH iterations (latency WIDTH+1). Results must be identical to the defined case.

Test Plan:
- DIVU opa=100, opb=7 -> stall high cycles 0-32; hilo_we in cycle 33 with lo=14, hi=2; busy low in cycle 34.
- DIV opa=0xFFFFFFF9 (-7), opb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- DIV opa=0x80000000, opb=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU same operands -> lo=0, hi=0x80000000.
- DIVU opa=0x12345678, opb=0 -> lo=0xFFFFFFFF, hi=0x12345678.
  - With DIV_ZERO_FAST_EN: hilo_we in cycle 1.
  - Without: hilo_we in cycle 33.
- Accept 100/7, assert cancel in cycle 10 -> stall drops that cycle; IDLE in cycle 11; no hilo_we; hi_out/lo_out unchanged. A following start is accepted normally.
- Accept, then pull rst low in cycle 5 -> all outputs 0 immediately; after release, a new DIVU 9/3 gives lo=3, hi=0 in cycle 33.
